div_issue_ctrl: RTL and testbench
=================================

Name: div_issue_ctrl

Overview:
- Initiator side of the divider's Run/Ready control interface.
- Accepts divide requests from the pipeline over a valid/ready handshake, holds the operands stable and clears the divider sequencer.
- Drives Run until Ready, captures quotient/remainder, then returns a result over a second valid/ready handshake.
- Sits between the execute-stage issue logic and the divider datapath plus its step-count controller.

Parameters:
- WIDTH, 32, operand/result width in bits.
- TIMEOUT_CYCLES, 48, Run cycles allowed before watchdog fires (used only with DIV_TIMEOUT_EN).

Ports:
- clk  in  1  rising-edge clock
- Reset  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_dividend  in  WIDTH  dividend, sampled on handshake
- req_divisor  in  WIDTH  divisor, sampled on handshake
- div_Reset  out  1  clear pulse to divider sequencer
- div_Run  out  1  run enable to divider sequencer
- div_dividend  out  WIDTH  registered dividend to datapath
- div_divisor  out  WIDTH  registered divisor to datapath
- div_pre_finish  in  1  divider final step in progress
- div_Ready  in  1  divider result valid (level)
- div_quotient  in  WIDTH  divider quotient
- div_remainder  in  WIDTH  divider remainder
- rsp_valid  out  1  result present
- rsp_ready  in  1  consumer accepts result
- rsp_quotient  out  WIDTH  registered quotient
- rsp_remainder  out  WIDTH  registered remainder
- rsp_div_zero  out  1  divisor was zero
- rsp_error  out  1  protocol/timeout error on this result

Behaviour:
- Reset (async assert, sync release) sets:
  - State IDLE, req_ready=1.
  - div_Reset=1 while Reset is high, then 0.
  - div_Run=0, rsp_valid=0, all data registers 0, flags 0.
- FSM states: IDLE, CLEAR, RUN, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready, latch the operands into the div_* registers.
  - If divisor==0, go to RESP with quotient={WIDTH{1}}, remainder=dividend, rsp_div_zero=1. The divider is not started.
  - Otherwise go to CLEAR.
- CLEAR:
  - Exactly one cycle with div_Reset=1, div_Run=0.
  - Then go to RUN.
- RUN:
  - div_Run=1 and div_Reset=0.
  - Operands stay frozen.
  - On the first cycle div_Ready is sampled high, capture div_quotient/div_remainder into the rsp registers, drop div_Run, and go to RESP.
- div_Ready sampled high without div_pre_finish sampled high on any earlier RUN cycle is a protocol violation. Still capture, and set rsp_error=1.
- With a conforming divider, the nominal interval from entering RUN to capture is 34 cycles. rsp_valid rises the cycle after capture.
- RESP:
  - rsp_valid=1; outputs held stable until rsp_ready.
  - On rsp_valid&&rsp_ready: return to IDLE, clear rsp_valid/rsp_div_zero/rsp_error, and pulse div_Reset for one cycle in the same transition.
- req_ready=0 in CLEAR, RUN and RESP. No request overlap, no skid buffer. Throughput is one divide in flight.
- The RESP-to-IDLE transition does not accept a request on the same edge. A new request is accepted at the earliest the following cycle.
- rsp_ready high before rsp_valid has no effect.
- div_Ready sampled in IDLE/CLEAR/RESP is ignored.
- Reset mid-operation (any state) aborts:
  - The result is discarded; rsp_valid=0 immediately (async).
  - div_Run=0, div_Reset=1 until Reset deasserts.

Optional Feature:
- DIV_TIMEOUT_EN defined:
  - Counter of RUN cycles, width clog2(TIMEOUT_CYCLES+1).
  - If the count reaches TIMEOUT_CYCLES without div_Ready: drop div_Run, go to RESP with quotient=0, remainder=0, rsp_error=1.
  - Counter clears on entering RUN.
- Undefined: no counter; RUN waits indefinitely for div_Ready.

Decomposition:
- Shared package div_pkg holds:
  - FSM state typedef (IDLE/CLEAR/RUN/RESP).
  - DIV_WIDTH default.
  - DIV_STEPS=32 and DIV_NOMINAL_LATENCY=34.
  - Divide-by-zero result constant encoding.
- Single module is natural. Optional sub-module div_watchdog holds the timeout counter, instantiated only under DIV_TIMEOUT_EN.

Test Plan:
- 100/7 with a model divider asserting pre_finish at Run cycle 33 and Ready at 34 → rsp_quotient=14, rsp_remainder=2, rsp_error=0; rsp_valid rises 36 cycles after the request handshake.
- Divisor=0, dividend=0x1234 → no div_Run ever, rsp_valid 1 cycle after handshake, quotient=0xFFFFFFFF, remainder=0x1234, rsp_div_zero=1.
- rsp_ready held low 10 cycles after rsp_valid → outputs stable, req_ready=0 throughout; on accept, one-cycle div_Reset pulse, req_ready=1 next cycle.
- Model asserts Ready at Run cycle 5 with no pre_finish → captured result returned with rsp_error=1.
- Reset asserted at Run cycle 20 → div_Run and rsp_valid low asynchronously; after release, 9/3 completes with quotient=3, remainder=0.
- DIV_TIMEOUT_EN with divider never asserting Ready → after 48 Run cycles, div_Run=0, rsp_valid=1, rsp_error=1, quotient=0.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and constants for the divider issue controller.
package div_pkg;

  localparam int DIV_WIDTH           = 32;
  localparam int DIV_STEPS           = 32;
  localparam int DIV_NOMINAL_LATENCY = DIV_STEPS + 2;

  // Divide-by-zero answers with every quotient bit set and the dividend as remainder.
  localparam logic DIV_ZERO_QUOTIENT_BIT = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_RUN   = 2'd2,
    ST_RESP  = 2'd3
  } div_state_e;

endpackage

// File: rtl/div_issue_ctrl_if.sv
// Request, divider and response signals of the divider issue controller.
interface div_issue_ctrl_if
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) ();

  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_dividend;
  logic [WIDTH-1:0] req_divisor;

  logic             div_Reset;
  logic             div_Run;
  logic [WIDTH-1:0] div_dividend;
  logic [WIDTH-1:0] div_divisor;
  logic             div_pre_finish;
  logic             div_Ready;
  logic [WIDTH-1:0] div_quotient;
  logic [WIDTH-1:0] div_remainder;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_quotient;
  logic [WIDTH-1:0] rsp_remainder;
  logic             rsp_div_zero;
  logic             rsp_error;

  modport slave (
    input  req_valid, req_dividend, req_divisor,
    input  div_pre_finish, div_Ready, div_quotient, div_remainder,
    input  rsp_ready,
    output req_ready,
    output div_Reset, div_Run, div_dividend, div_divisor,
    output rsp_valid, rsp_quotient, rsp_remainder, rsp_div_zero, rsp_error
  );

  modport master (
    output req_valid, req_dividend, req_divisor,
    output div_pre_finish, div_Ready, div_quotient, div_remainder,
    output rsp_ready,
    input  req_ready,
    input  div_Reset, div_Run, div_dividend, div_divisor,
    input  rsp_valid, rsp_quotient, rsp_remainder, rsp_div_zero, rsp_error
  );

endinterface

// File: rtl/div_watchdog.sv
// Counts consecutive Run cycles and flags the last one allowed before timeout.
module div_watchdog #(
  parameter int TIMEOUT_CYCLES = 48
) (
  input  logic clk,
  input  logic rst,
  input  logic run_i,
  output logic expired_o
);

  localparam int                CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // The controller always passes through CLEAR, so the count is zero on RUN entry.
  always_comb begin
    count_d = '0;
    if (run_i) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_o = run_i && (count_q == CNT_LAST);

endmodule

// File: rtl/div_issue_ctrl.sv
// Divider Run/Ready initiator: request handshake, clear/run sequencing, result handshake.
// Optional Run watchdog enabled by defining DIV_TIMEOUT_EN.
module div_issue_ctrl
  import div_pkg::*;
#(
  parameter int WIDTH          = DIV_WIDTH,
  parameter int TIMEOUT_CYCLES = 48
) (
  input  logic       clk,
  input  logic       Reset,
  div_issue_ctrl_if.slave bus
);

  div_state_e       state_q,      state_d;
  logic [WIDTH-1:0] dividend_q,   dividend_d;
  logic [WIDTH-1:0] divisor_q,    divisor_d;
  logic [WIDTH-1:0] quotient_q,   quotient_d;
  logic [WIDTH-1:0] remainder_q,  remainder_d;
  logic             div_zero_q,   div_zero_d;
  logic             error_q,      error_d;
  logic             pre_seen_q,   pre_seen_d;
  logic             div_rst_q,    div_rst_d;
  logic             timeout;

  if (TIMEOUT_CYCLES < 1) begin : g_timeout_param_check
    $error("TIMEOUT_CYCLES must be at least 1");
  end

`ifdef DIV_TIMEOUT_EN
  div_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk       (clk),
    .rst       (Reset),
    .run_i     (state_q == ST_RUN),
    .expired_o (timeout)
  );
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    dividend_d  = dividend_q;
    divisor_d   = divisor_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    div_zero_d  = div_zero_q;
    error_d     = error_q;
    pre_seen_d  = pre_seen_q;
    div_rst_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          dividend_d = bus.req_dividend;
          divisor_d  = bus.req_divisor;
          if (bus.req_divisor == '0) begin
            quotient_d  = {WIDTH{DIV_ZERO_QUOTIENT_BIT}};
            remainder_d = bus.req_dividend;
            div_zero_d  = 1'b1;
            error_d     = 1'b0;
            state_d     = ST_RESP;
          end else begin
            div_rst_d = 1'b1;
            state_d   = ST_CLEAR;
          end
        end
      end

      ST_CLEAR: begin
        pre_seen_d = 1'b0;
        state_d    = ST_RUN;
      end

      ST_RUN: begin
        // Ready is legal only after pre_finish was seen on an earlier Run cycle.
        if (bus.div_Ready) begin
          quotient_d  = bus.div_quotient;
          remainder_d = bus.div_remainder;
          div_zero_d  = 1'b0;
          error_d     = !pre_seen_q;
          state_d     = ST_RESP;
        end else if (timeout) begin
          quotient_d  = '0;
          remainder_d = '0;
          div_zero_d  = 1'b0;
          error_d     = 1'b1;
          state_d     = ST_RESP;
        end else if (bus.div_pre_finish) begin
          pre_seen_d = 1'b1;
        end
      end

      ST_RESP: begin
        if (bus.rsp_ready) begin
          div_zero_d = 1'b0;
          error_d    = 1'b0;
          div_rst_d  = 1'b1;
          state_d    = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= ST_IDLE;
      dividend_q  <= '0;
      divisor_q   <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      div_zero_q  <= 1'b0;
      error_q     <= 1'b0;
      pre_seen_q  <= 1'b0;
      div_rst_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      dividend_q  <= dividend_d;
      divisor_q   <= divisor_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      div_zero_q  <= div_zero_d;
      error_q     <= error_d;
      pre_seen_q  <= pre_seen_d;
      div_rst_q   <= div_rst_d;
    end
  end

  // Reset is ORed in so the sequencer clear drops as soon as Reset releases.
  assign bus.div_Reset     = div_rst_q | Reset;
  assign bus.div_Run       = (state_q == ST_RUN);
  assign bus.req_ready     = (state_q == ST_IDLE);
  assign bus.rsp_valid     = (state_q == ST_RESP);
  assign bus.div_dividend  = dividend_q;
  assign bus.div_divisor   = divisor_q;
  assign bus.rsp_quotient  = quotient_q;
  assign bus.rsp_remainder = remainder_q;
  assign bus.rsp_div_zero  = div_zero_q;
  assign bus.rsp_error     = error_q;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Self-checking bench for div_issue_ctrl with a behavioural divider model.
module tb_div_issue_ctrl;
  import div_pkg::*;

  localparam int W  = 32;
  localparam int TO = 48;
`ifdef DIV_TIMEOUT_EN
  localparam bit TIMEOUT_ON = 1'b1;
`else
  localparam bit TIMEOUT_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic Reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  div_issue_ctrl_if #(.WIDTH(W)) bus ();

  div_issue_ctrl #(.WIDTH(W), .TIMEOUT_CYCLES(TO)) dut (
    .clk   (clk),
    .Reset (Reset),
    .bus   (bus)
  );

  // Divider model: pre_finish on Run cycle m_pf (0 = never), Ready from Run cycle m_rdy.
  int unsigned m_pf;
  int unsigned m_rdy;
  int unsigned m_cnt;

  always @(posedge clk) begin
    if (Reset || bus.div_Reset) m_cnt <= 0;
    else if (bus.div_Run)       m_cnt <= m_cnt + 1;
  end

  assign bus.div_pre_finish = bus.div_Run && (m_cnt + 1 == m_pf);
  assign bus.div_Ready      = bus.div_Run && (m_cnt + 1 >= m_rdy);
  assign bus.div_quotient   = (bus.div_divisor == '0) ? '1 : bus.div_dividend / bus.div_divisor;
  assign bus.div_remainder  = (bus.div_divisor == '0) ? bus.div_dividend : bus.div_dividend % bus.div_divisor;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: outcome of one request from the divide rules alone.
  function automatic void ref_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                    input int unsigned pf, input int unsigned rdy,
                                    output logic [W-1:0] q, output logic [W-1:0] r,
                                    output logic dz, output logic err, output int lat);
    if (b == 0) begin
      q = '1; r = a; dz = 1'b1; err = 1'b0; lat = 1;
    end else if (TIMEOUT_ON && rdy > TO) begin
      q = '0; r = '0; dz = 1'b0; err = 1'b1; lat = TO + 2;
    end else begin
      q = a / b; r = a % b; dz = 1'b0;
      err = !(pf != 0 && pf < rdy);
      lat = int'(rdy) + 2;
    end
  endfunction

  task automatic do_txn(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int unsigned pf, input int unsigned rdy, input int hold,
                        input bit early, input logic [W-1:0] eq, input logic [W-1:0] er,
                        input logic edz, input logic eerr, input int elat);
    int w;
    int lat;
    int runs;
    @(negedge clk);
    m_pf = pf;
    m_rdy = rdy;
    bus.req_valid = 1'b1;
    bus.req_dividend = a;
    bus.req_divisor = b;
    w = 0;
    while (!bus.req_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    chk({tag, " req_ready"}, 128'(bus.req_ready), 128'(1'b1));
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_dividend = $urandom;
    bus.req_divisor = $urandom;
    bus.rsp_ready = early;
    lat = 1;
    runs = 0;
    while (!bus.rsp_valid && lat < 200) begin
      if (bus.div_Run) runs++;
      @(negedge clk);
      lat++;
    end
    chk({tag, " latency"}, 128'(lat), 128'(elat));
    chk({tag, " run_cycles"}, 128'(runs), 128'(edz ? 0 : elat - 2));
    chk({tag, " result"},
        {bus.rsp_quotient, bus.rsp_remainder, bus.rsp_div_zero, bus.rsp_error, bus.div_Run},
        {eq, er, edz, eerr, 1'b0});
    chk({tag, " operands"}, {bus.div_dividend, bus.div_divisor}, {a, b});
    if (!early) begin
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        chk({tag, " hold"},
            {bus.rsp_valid, bus.req_ready, bus.rsp_quotient, bus.rsp_remainder,
             bus.rsp_div_zero, bus.rsp_error, bus.div_Run},
            {1'b1, 1'b0, eq, er, edz, eerr, 1'b0});
      end
      bus.rsp_ready = 1'b1;
    end
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    chk({tag, " accept"},
        {bus.rsp_valid, bus.req_ready, bus.div_Reset, bus.rsp_div_zero, bus.rsp_error},
        {1'b0, 1'b1, 1'b1, 1'b0, 1'b0});
    @(negedge clk);
    chk({tag, " div_Reset pulse end"}, 128'(bus.div_Reset), 128'(1'b0));
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    int unsigned  pf;
    int unsigned  rdy;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    logic         err;
    int           lat;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [W-1:0] ra, rb, rq, rr;
    logic         rdz, rerr;
    int           rlat;
    int unsigned  rpf, rrdy;
    int           k;
    int           runs;

    vecs[0] = '{32'd100,        32'd7, 33, 34, 32'd14,        32'd2,      1'b0, 1'b0, 36};
    vecs[1] = '{32'h1234,       32'd0, 0,  0,  32'hFFFF_FFFF, 32'h1234,   1'b1, 1'b0, 1};
    vecs[2] = '{32'd5,          32'd0, 33, 34, 32'hFFFF_FFFF, 32'd5,      1'b1, 1'b0, 1};
    vecs[3] = '{32'd9,          32'd3, 33, 34, 32'd3,         32'd0,      1'b0, 1'b0, 36};
    vecs[4] = '{32'd20,         32'd6, 0,  5,  32'd3,         32'd2,      1'b0, 1'b1, 7};
    vecs[5] = '{32'hFFFF_FFFF,  32'd1, 10, 10, 32'hFFFF_FFFF, 32'd0,      1'b0, 1'b1, 12};
    vecs[6] = '{32'd7,          32'd9, 1,  2,  32'd0,         32'd7,      1'b0, 1'b0, 4};
    vecs[7] = '{32'd0,          32'd5, 33, 34, 32'd0,         32'd0,      1'b0, 1'b0, 36};

    Reset = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_dividend = '0;
    bus.req_divisor = '0;
    bus.rsp_ready = 1'b0;
    m_pf = 0;
    m_rdy = 1000;
    repeat (2) @(negedge clk);
    chk("reset handshake", {bus.req_ready, bus.div_Reset, bus.div_Run, bus.rsp_valid},
        {1'b1, 1'b1, 1'b0, 1'b0});
    chk("reset data", {bus.div_dividend, bus.div_divisor, bus.rsp_quotient, bus.rsp_remainder,
                       bus.rsp_div_zero, bus.rsp_error}, 128'(0));
    Reset = 1'b0;
    #1;
    chk("reset release div_Reset", 128'(bus.div_Reset), 128'(1'b0));

    for (int i = 0; i < 8; i++) begin
      do_txn($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].pf, vecs[i].rdy, 2, 1'b0,
             vecs[i].q, vecs[i].r, vecs[i].dz, vecs[i].err, vecs[i].lat);
    end

    do_txn("early_rsp_ready", 32'd100, 32'd7, 33, 34, 0, 1'b1, 32'd14, 32'd2, 1'b0, 1'b0,
           DIV_NOMINAL_LATENCY + 2);
    do_txn("hold10", 32'd1000, 32'd33, 33, 34, 10, 1'b0, 32'd30, 32'd10, 1'b0, 1'b0, 36);

    // Reset asserted in the middle of Run cycle 20.
    @(negedge clk);
    m_pf = 33;
    m_rdy = 34;
    bus.req_valid = 1'b1;
    bus.req_dividend = 32'd50;
    bus.req_divisor = 32'd5;
    @(negedge clk);
    bus.req_valid = 1'b0;
    k = 0;
    runs = 0;
    while (runs < 20 && k < 100) begin
      @(negedge clk);
      if (bus.div_Run) runs++;
      k++;
    end
    chk("midrun reached run 20", 128'(runs), 128'(20));
    #2 Reset = 1'b1;
    #1;
    chk("midrun abort", {bus.div_Run, bus.rsp_valid, bus.div_Reset, bus.req_ready},
        {1'b0, 1'b0, 1'b1, 1'b1});
    @(negedge clk);
    chk("midrun div_Reset held", 128'(bus.div_Reset), 128'(1'b1));
    Reset = 1'b0;
    #1;
    chk("midrun release", {bus.div_Reset, bus.div_Run, bus.rsp_valid}, {1'b0, 1'b0, 1'b0});
    do_txn("after_reset", 32'd9, 32'd3, 33, 34, 1, 1'b0, 32'd3, 32'd0, 1'b0, 1'b0, 36);

`ifdef DIV_TIMEOUT_EN
    do_txn("timeout", 32'd77, 32'd7, 0, 1000, 3, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1, TO + 2);
`endif

    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      k = int'($urandom_range(0, 7));
      rb = (k == 0) ? '0 : (k < 3) ? W'($urandom_range(1, 15)) : W'($urandom);
      rrdy = $urandom_range(1, 40);
      rpf = $urandom_range(0, rrdy);
      ref_model(ra, rb, rpf, rrdy, rq, rr, rdz, rerr, rlat);
      k = int'($urandom_range(0, 4));
      do_txn($sformatf("rand%0d", i), ra, rb, rpf, rrdy, k,
             (k == 0) && ($urandom_range(0, 1) == 1), rq, rr, rdz, rerr, rlat);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
